// File: rtl/store_buffer.sv
// store_buffer: in-order write-back store buffer with a load hazard probe.
// Accepted stores with a non-zero byte mask are queued and then drained to
// data memory one request at a time. A load probe reports any held entry,
// including the head that is currently in flight, that shares its 8-byte
// line and overlaps at least one byte of the load.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         st_valid_i,
   output logic                         st_ready_o,
   input  logic [63:0]                  st_addr_i,
   input  logic [63:0]                  st_data_i,
   input  logic [7:0]                   st_mask_i,
   output logic                         mem_req_o,
   output logic [63:0]                  mem_addr_o,
   output logic [63:0]                  mem_data_o,
   output logic [7:0]                   mem_mask_o,
   input  logic                         mem_ack_i,
   input  logic                         ld_valid_i,
   input  logic [63:0]                  ld_addr_i,
   input  logic [7:0]                   ld_mask_i,
   output logic                         ld_hit_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = 61;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_n;
   logic [PW-1:0]    head;
   logic [PW-1:0]    head_n;
   logic [PW-1:0]    tail;
   logic [PW-1:0]    tail_n;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_n;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] valid_n;

   logic [AW-1:0]    ent_addr [DEPTH];
   logic [63:0]      ent_data [DEPTH];
   logic [7:0]       ent_mask [DEPTH];

   logic             push;
   logic             pop;
   logic             accept;
   logic             hit;

   // Low address bits are irrelevant: both stores and loads work per 8-byte line.
   logic             unused_low_bits;
   assign unused_low_bits = ^{st_addr_i[2:0], ld_addr_i[2:0]};

   // Handshake: ready whenever not full and out of reset; zero-mask stores are
   // accepted but never allocated.
   assign st_ready_o = resetn & (count != CW'(DEPTH));
   assign accept     = st_valid_i & st_ready_o;
   assign push       = accept & (|st_mask_i);
   assign pop        = (state == REQ) & mem_ack_i;

   // Pointer, occupancy and entry-valid next values.
   always_comb begin
      head_n  = head;
      tail_n  = tail;
      count_n = count;
      valid_n = valid;
      if (pop) begin
         head_n        = head + PW'(1);
         valid_n[head] = 1'b0;
      end
      if (push) begin
         tail_n        = tail + PW'(1);
         valid_n[tail] = 1'b1;
      end
      case ({push, pop})
         2'b10:   count_n = count + CW'(1);
         2'b01:   count_n = count - CW'(1);
         default: count_n = count;
      endcase
   end

   // Drain FSM next state: request while anything is held.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_n = REQ;
            end
         end
         REQ: begin
            if (pop && (count_n == '0)) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         state <= state_n;
         head  <= head_n;
         tail  <= tail_n;
         count <= count_n;
         valid <= valid_n;
      end
   end

   // Entry payload storage; validity is tracked separately so no reset here.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[tail] <= st_addr_i[63:3];
         ent_data[tail] <= st_data_i;
         ent_mask[tail] <= st_mask_i;
      end
   end

   // Load hazard search over every valid entry; the incoming store is excluded.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (ent_addr[i] == ld_addr_i[63:3]) &&
             ((ent_mask[i] & ld_mask_i) != 8'h00)) begin
            hit = 1'b1;
         end
      end
   end

   assign ld_hit_o   = ld_valid_i & hit;
   assign mem_req_o  = (state == REQ);
   assign mem_addr_o = (state == REQ) ? {ent_addr[head], 3'b000} : 64'h0;
   assign mem_data_o = (state == REQ) ? ent_data[head] : 64'h0;
   assign mem_mask_o = (state == REQ) ? ent_mask[head] : 8'h00;
   assign empty_o    = (count == '0);
   assign count_o    = count;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios followed by randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        resetn;
   logic        st_valid_i;
   logic        st_ready_o;
   logic [63:0] st_addr_i;
   logic [63:0] st_data_i;
   logic [7:0]  st_mask_i;
   logic        mem_req_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_data_o;
   logic [7:0]  mem_mask_o;
   logic        mem_ack_i;
   logic        ld_valid_i;
   logic [63:0] ld_addr_i;
   logic [7:0]  ld_mask_i;
   logic        ld_hit_o;
   logic        empty_o;
   logic [2:0]  count_o;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .st_valid_i (st_valid_i),
      .st_ready_o (st_ready_o),
      .st_addr_i  (st_addr_i),
      .st_data_i  (st_data_i),
      .st_mask_i  (st_mask_i),
      .mem_req_o  (mem_req_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .mem_mask_o (mem_mask_o),
      .mem_ack_i  (mem_ack_i),
      .ld_valid_i (ld_valid_i),
      .ld_addr_i  (ld_addr_i),
      .ld_mask_i  (ld_mask_i),
      .ld_hit_o   (ld_hit_o),
      .empty_o    (empty_o),
      .count_o    (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [60:0] line;
      logic [63:0] data;
      logic [7:0]  mask;
   } ent_t;

   ent_t q[$];
   logic m_req;
   int   total;
   int   bad;
   int   writes;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance.
   task automatic cycle(input logic rst, input logic sv, input logic [63:0] sa,
                        input logic [63:0] sd, input logic [7:0] sm, input logic ack,
                        input logic lv, input logic [63:0] la, input logic [7:0] lm);
      logic        exp_ready;
      logic        exp_hit;
      logic        do_push;
      logic        do_pop;
      logic        was_nonempty;
      ent_t        e;
      resetn     = ~rst;
      st_valid_i = sv;
      st_addr_i  = sa;
      st_data_i  = sd;
      st_mask_i  = sm;
      mem_ack_i  = ack;
      ld_valid_i = lv;
      ld_addr_i  = la;
      ld_mask_i  = lm;
      #1;
      exp_ready = !rst && (q.size() != DEPTH);
      exp_hit   = 1'b0;
      foreach (q[i]) begin
         if (q[i].line == la[63:3] && (q[i].mask & lm) != 8'h00) exp_hit = lv;
      end
      check_eq("st_ready", 64'(st_ready_o), 64'(exp_ready));
      check_eq("count", 64'(count_o), 64'(q.size()));
      check_eq("empty", 64'(empty_o), 64'(q.size() == 0));
      check_eq("mem_req", 64'(mem_req_o), 64'(m_req));
      check_eq("ld_hit", 64'(ld_hit_o), 64'(exp_hit));
      if (m_req) begin
         check_eq("mem_addr", mem_addr_o, {q[0].line, 3'b000});
         check_eq("mem_data", mem_data_o, q[0].data);
         check_eq("mem_mask", 64'(mem_mask_o), 64'(q[0].mask));
      end else begin
         check_eq("mem_addr_idle", mem_addr_o, 64'h0);
         check_eq("mem_data_idle", mem_data_o, 64'h0);
         check_eq("mem_mask_idle", 64'(mem_mask_o), 64'h0);
      end
      do_push      = sv && exp_ready && (sm != 8'h00);
      do_pop       = m_req && ack;
      was_nonempty = (q.size() != 0);
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         m_req = 1'b0;
      end else begin
         if (do_pop) begin
            void'(q.pop_front());
            writes++;
         end
         if (do_push) begin
            e.line = sa[63:3];
            e.data = sd;
            e.mask = sm;
            q.push_back(e);
         end
         m_req = m_req ? (q.size() != 0) : was_nonempty;
      end
   endtask

   task automatic idle_cycle(input logic ack);
      cycle(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, ack, 1'b0, 64'h0, 8'h00);
   endtask

   task automatic push_cycle(input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] m, input logic ack);
      cycle(1'b0, 1'b1, a, d, m, ack, 1'b0, 64'h0, 8'h00);
   endtask

   task automatic probe_cycle(input logic [63:0] a, input logic [7:0] m, input logic ack);
      cycle(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, ack, 1'b1, a, m);
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] la;
      logic [7:0]  rm;
      total  = 0;
      bad    = 0;
      writes = 0;
      m_req  = 1'b0;
      resetn     = 1'b0;
      st_valid_i = 1'b0;
      st_addr_i  = '0;
      st_data_i  = '0;
      st_mask_i  = '0;
      mem_ack_i  = 1'b0;
      ld_valid_i = 1'b0;
      ld_addr_i  = '0;
      ld_mask_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      cycle(1'b1, 1'b1, 64'h8, 64'h1, 8'hFF, 1'b1, 1'b1, 64'h8, 8'hFF);

      // Single store, ack after three request cycles.
      push_cycle(64'h1000, 64'h00000000_AABB0000, 8'h0C, 1'b0);
      repeat (4) idle_cycle(1'b0);
      idle_cycle(1'b1);
      idle_cycle(1'b0);

      // Fill to DEPTH, offer a fifth, then drain one per cycle.
      for (int i = 0; i < 5; i++) push_cycle(64'h3000 + 64'(i * 8), 64'(i + 100), 8'hFF, 1'b0);
      for (int i = 0; i < 6; i++) idle_cycle(1'b1);

      // Wrap with simultaneous push/pop keeping two entries resident.
      push_cycle(64'h4000, 64'hA0, 8'h01, 1'b0);
      push_cycle(64'h4008, 64'hA1, 8'h02, 1'b0);
      for (int i = 0; i < 10; i++) push_cycle(64'h4010 + 64'(i * 8), 64'hB0 + 64'(i), 8'h80, 1'b1);
      for (int i = 0; i < 3; i++) idle_cycle(1'b1);

      // Hazard probes against a single held entry.
      push_cycle(64'h2008, 64'hCAFE, 8'hF0, 1'b0);
      probe_cycle(64'h200C, 8'h30, 1'b0);
      probe_cycle(64'h200C, 8'h0F, 1'b0);
      probe_cycle(64'h2010, 8'hF0, 1'b0);
      probe_cycle(64'h200C, 8'h30, 1'b1);
      probe_cycle(64'h200C, 8'h30, 1'b0);

      // Zero-mask store is swallowed.
      push_cycle(64'h5000, 64'h1234, 8'h00, 1'b0);
      idle_cycle(1'b0);
      idle_cycle(1'b0);

      // Reset while a request is outstanding, then a stray ack.
      for (int i = 0; i < 3; i++) push_cycle(64'h6000 + 64'(i * 8), 64'(i), 8'h0F, 1'b0);
      idle_cycle(1'b0);
      cycle(1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 8'h00);
      idle_cycle(1'b1);
      idle_cycle(1'b0);

      // Randomized traffic over a small address window to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         ra = {58'h0, 3'($urandom_range(0, 7)), 3'($urandom)};
         la = {58'h0, 3'($urandom_range(0, 7)), 3'($urandom)};
         rm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), ra,
               {$urandom, $urandom}, rm, ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 1), la, 8'($urandom));
      end
      check_eq("writes_seen", 64'(writes > 100), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of buffered store entries (power of two, at least 2).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port st_valid_i  input  1  an aligned store is offered.
REQ-005 The block SHALL have port st_ready_o  output  1  the buffer can accept a store this cycle.
REQ-006 The block SHALL have port st_addr_i  input  64  store address; only bits [63:3] are used.
REQ-007 The block SHALL have port st_data_i  input  64  lane-aligned store data from store alignment.
REQ-008 The block SHALL have port st_mask_i  input  8  byte-enable mask from store alignment.
REQ-009 The block SHALL have port mem_req_o  output  1  write request to data memory.
REQ-010 The block SHALL have port mem_addr_o  output  64  write address, {head addr[63:3], 3'b000}.
REQ-011 The block SHALL have port mem_data_o  output  64  write data.
REQ-012 The block SHALL have port mem_mask_o  output  8  byte enables.
REQ-013 The block SHALL have port mem_ack_i  input  1  memory accepted the current request.
REQ-014 The block SHALL have port ld_valid_i  input  1  a load is probing for a hazard.
REQ-015 The block SHALL have port ld_addr_i  input  64  load address; bits [63:3] are compared.
REQ-016 The block SHALL have port ld_mask_i  input  8  load byte mask.
REQ-017 The block SHALL have port ld_hit_o  output  1  the load overlaps a buffered store, so the load must stall.
REQ-018 The block SHALL have port empty_o  output  1  no entries are held.
REQ-019 The block SHALL have port count_o  output  $clog2(DEPTH+1)  number of entries held.

Function
REQ-020 The buffer SHALL be an in-order FIFO with head/tail pointers that wrap modulo DEPTH and a separate occupancy count.
REQ-021 st_ready_o SHALL equal (count_o != DEPTH) with no full-cycle pass-through; a push occurs when st_valid_i and st_ready_o are both high.
REQ-022 A push with st_mask_i == 8'h00 SHALL be accepted (handshake completes) and dropped, with no entry allocated.
REQ-023 The FSM SHALL have states IDLE and REQ; mem_req_o SHALL be 1 exactly in REQ.
REQ-024 IDLE SHALL go to REQ on the edge where count_o is nonzero; the first request therefore follows acceptance into an empty buffer by 1 cycle.
REQ-025 In REQ, mem_addr_o, mem_data_o and mem_mask_o SHALL present the head entry and stay stable until mem_ack_i.
REQ-026 In REQ with mem_ack_i high, the head SHALL pop on that edge; the FSM SHALL stay in REQ if entries remain after the pop, else go to IDLE.
REQ-027 Back-to-back entries SHALL issue with no idle cycle.
REQ-028 mem_ack_i in IDLE SHALL be ignored.
REQ-029 A simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-030 In IDLE, mem_addr_o, mem_data_o and mem_mask_o SHALL be 0.
REQ-031 ld_hit_o SHALL be combinational: ld_valid_i AND (some held entry, including the head in flight, has addr[63:3] equal to ld_addr_i[63:3] and (entry mask & ld_mask_i) != 0).
REQ-032 An entry popped on edge N SHALL NOT contribute to ld_hit_o after edge N.
REQ-033 A store pushed on edge N SHALL contribute to ld_hit_o from the cycle after edge N.
REQ-034 The same-cycle incoming store SHALL NOT be compared by the ld_hit_o check.
REQ-035 empty_o SHALL equal (count_o == 0).

Reset
REQ-036 When resetn is low at a clock edge, the pointers, count_o and FSM SHALL clear to 0 / IDLE and all entries SHALL be invalidated.
REQ-037 Entry data SHALL NOT require reset.
REQ-038 While resetn is low, st_ready_o SHALL be 0.
REQ-039 After reset: mem_req_o=0, mem_addr_o/data_o/mask_o=0, ld_hit_o=0, empty_o=1, count_o=0.
REQ-040 Reset during REQ SHALL abandon the request: mem_req_o=0 after the reset edge, pending stores are discarded, and an ack arriving afterwards is ignored.

Verification
REQ-041 Single store: push addr=0x1000, data=0x00000000_AABB0000, mask=8'h0C with mem_ack_i held low, then ack after 3 cycles -> mem_req_o=1 in the next cycle with mem_addr_o=0x1000 and mem_mask_o=8'h0C; payload stable 3 cycles; empty_o=1 after the ack edge.
REQ-042 Fill: push 4 stores with no ack -> count_o=4 and st_ready_o=0; a 5th offer is not accepted; acks 1/cycle -> 4 consecutive mem_req_o cycles in order, then IDLE.
REQ-043 Wrap plus simultaneous push/pop: keep 2 entries resident while pushing and acking every cycle for 10 cycles -> count_o stays 2; all 10 writes emerge in order with correct data.
REQ-044 Hazard: entry at addr 0x2008 mask 8'hF0; load 0x200C mask 8'h30 -> ld_hit_o=1; load mask 8'h0F -> 0; load 0x2010 mask 8'hF0 -> 0; after the ack edge, the same load -> 0.
REQ-045 Zero-mask store: push mask 8'h00 -> handshake completes, count_o stays 0, and no mem_req_o.
REQ-046 Reset mid-request: 3 entries with mem_req_o=1, then resetn low for one edge -> count_o=0 and mem_req_o=0; an ack the next cycle causes no change.
